// File: rtl/komandara_bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between the fetch port
// (P0) and the load/store port (P1). Grants are combinational, the BRAM
// response returns one cycle after the grant and is steered back to the
// port that issued it. A saturating counter tracks contention cycles.
module komandara_bram_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,

    input  logic                    i_p0_req,
    input  logic                    i_p0_we,
    input  logic [ADDR_WIDTH-1:0]   i_p0_addr,
    input  logic [DATA_WIDTH-1:0]   i_p0_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_p0_wstrb,
    output logic                    o_p0_gnt,
    output logic                    o_p0_rvalid,
    output logic [DATA_WIDTH-1:0]   o_p0_rdata,

    input  logic                    i_p1_req,
    input  logic                    i_p1_we,
    input  logic [ADDR_WIDTH-1:0]   i_p1_addr,
    input  logic [DATA_WIDTH-1:0]   i_p1_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_p1_wstrb,
    output logic                    o_p1_gnt,
    output logic                    o_p1_rvalid,
    output logic [DATA_WIDTH-1:0]   o_p1_rdata,

    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
    input  logic                    i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,

    input  logic                    i_cnt_clr,
    output logic [CNT_WIDTH-1:0]    o_conflict_cnt
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // last_q remembers the most recently granted port; the other one wins a tie
    logic                 last_q, last_d;
    logic                 owner_vld_q, owner_vld_d;
    logic                 owner_q, owner_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 grant0;
    logic                 grant1;
    logic                 contention;

    assign contention = i_p0_req & i_p1_req;

    // Combinational arbitration: a lone requester wins, a tie goes to the port not granted last
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (i_rst_n) begin
            if (contention) begin
                grant0 = last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = i_p0_req;
                grant1 = i_p1_req;
            end
        end
    end

    assign o_p0_gnt    = grant0;
    assign o_p1_gnt    = grant1;

    assign o_mem_req   = grant0 | grant1;
    assign o_mem_we    = grant1 ? i_p1_we    : (grant0 & i_p0_we);
    assign o_mem_wstrb = grant1 ? i_p1_wstrb : (grant0 ? i_p0_wstrb : {STRB_WIDTH{1'b0}});
    assign o_mem_addr  = grant1 ? i_p1_addr  : i_p0_addr;
    assign o_mem_wdata = grant1 ? i_p1_wdata : i_p0_wdata;

    // The BRAM answers every accepted access one cycle later; only the issuing port sees it
    assign o_p0_rvalid = owner_vld_q & ~owner_q & i_mem_rvalid;
    assign o_p1_rvalid = owner_vld_q &  owner_q & i_mem_rvalid;
    assign o_p0_rdata  = i_mem_rdata;
    assign o_p1_rdata  = i_mem_rdata;

    assign o_conflict_cnt = cnt_q;

    // Next-state for the round-robin pointer, response owner and contention counter
    always_comb begin
        last_d      = last_q;
        owner_vld_d = grant0 | grant1;
        owner_d     = grant1;
        cnt_d       = cnt_q;
        if (grant0 | grant1) begin
            last_d = grant1;
        end
        if (i_cnt_clr) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else if (contention && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous active-low reset; P0 wins the first tie after reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_q      <= 1'b1;
            owner_vld_q <= 1'b0;
            owner_q     <= 1'b0;
            cnt_q       <= {CNT_WIDTH{1'b0}};
        end else begin
            last_q      <= last_d;
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_komandara_bram_arbiter.sv
// Self-checking bench for komandara_bram_arbiter. A behavioural BRAM sits
// behind the arbiter; a reference model predicts grants, routed responses,
// read data and the contention counter from the arbitration rules.
module tb_komandara_bram_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req0, we0, req1, we1, cntClr;
    logic [13:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  wstrb0, wstrb1;

    logic        gnt0, gnt1, rv0, rv1;
    logic [31:0] rdata0, rdata1;
    logic        memReq, memWe;
    logic [13:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memWstrb;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic [15:0] cnt;

    logic        d2Gnt0, d2Gnt1, d2Rv0, d2Rv1, d2MemReq, d2MemWe;
    logic [31:0] d2Rdata0, d2Rdata1, d2MemWdata;
    logic [13:0] d2MemAddr;
    logic [3:0]  d2MemWstrb;
    logic [1:0]  cnt2;

    logic        preloadEn;
    logic [5:0]  preloadAddr;
    logic [31:0] preloadData;
    logic [31:0] memArr [0:63];

    // reference model state
    logic [31:0] refMem [0:63];
    bit          prioP0;
    bit          rspValid;
    bit          rspPort;
    logic [31:0] rspData;
    int          refCnt, refCnt2;
    bit          eg0, eg1, erv0, erv1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    komandara_bram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_p0_req(req0), .i_p0_we(we0), .i_p0_addr(addr0), .i_p0_wdata(wdata0), .i_p0_wstrb(wstrb0),
        .o_p0_gnt(gnt0), .o_p0_rvalid(rv0), .o_p0_rdata(rdata0),
        .i_p1_req(req1), .i_p1_we(we1), .i_p1_addr(addr1), .i_p1_wdata(wdata1), .i_p1_wstrb(wstrb1),
        .o_p1_gnt(gnt1), .o_p1_rvalid(rv1), .o_p1_rdata(rdata1),
        .o_mem_req(memReq), .o_mem_we(memWe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
        .o_mem_wstrb(memWstrb), .i_mem_rvalid(memRvalid), .i_mem_rdata(memRdata),
        .i_cnt_clr(cntClr), .o_conflict_cnt(cnt)
    );

    // Narrow-counter instance sharing all inputs, used to observe saturation
    komandara_bram_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .CNT_WIDTH(2)) dut2 (
        .i_clk(clk), .i_rst_n(rstN),
        .i_p0_req(req0), .i_p0_we(we0), .i_p0_addr(addr0), .i_p0_wdata(wdata0), .i_p0_wstrb(wstrb0),
        .o_p0_gnt(d2Gnt0), .o_p0_rvalid(d2Rv0), .o_p0_rdata(d2Rdata0),
        .i_p1_req(req1), .i_p1_we(we1), .i_p1_addr(addr1), .i_p1_wdata(wdata1), .i_p1_wstrb(wstrb1),
        .o_p1_gnt(d2Gnt1), .o_p1_rvalid(d2Rv1), .o_p1_rdata(d2Rdata1),
        .o_mem_req(d2MemReq), .o_mem_we(d2MemWe), .o_mem_addr(d2MemAddr), .o_mem_wdata(d2MemWdata),
        .o_mem_wstrb(d2MemWstrb), .i_mem_rvalid(memRvalid), .i_mem_rdata(memRdata),
        .i_cnt_clr(cntClr), .o_conflict_cnt(cnt2)
    );

    // Read-first single-port BRAM with one-cycle response; it has no reset
    always @(posedge clk) begin
        memRvalid <= memReq;
        if (preloadEn) begin
            memArr[preloadAddr] <= preloadData;
        end else if (memReq) begin
            memRdata <= memArr[memAddr[5:0]];
            if (memWe) begin
                for (int b = 0; b < 4; b++) begin
                    if (memWstrb[b]) memArr[memAddr[5:0]][8*b +: 8] <= memWdata[8*b +: 8];
                end
            end
        end
    end

    // Expected outputs for the current cycle from the model state and present inputs
    task automatic predict();
        if (!rstN) begin
            eg0 = 0; eg1 = 0;
        end else if (req0 && req1) begin
            eg0 = prioP0; eg1 = !prioP0;
        end else begin
            eg0 = req0; eg1 = req1;
        end
        erv0 = rspValid && (rspPort == 1'b0);
        erv1 = rspValid && (rspPort == 1'b1);
    endtask

    // Advance the model across one clock edge, then move to just after the edge
    task automatic edgeAdvance();
        logic [5:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          w;
        predict();
        if (!rstN) begin
            rspValid = 0; rspPort = 0; prioP0 = 1; refCnt = 0; refCnt2 = 0;
        end else begin
            if (eg0 || eg1) begin
                rspPort  = eg1;
                a = eg1 ? addr1[5:0] : addr0[5:0];
                d = eg1 ? wdata1 : wdata0;
                s = eg1 ? wstrb1 : wstrb0;
                w = eg1 ? we1 : we0;
                rspValid = 1;
                rspData  = refMem[a];
                if (w) begin
                    for (int b = 0; b < 4; b++) if (s[b]) refMem[a][8*b +: 8] = d[8*b +: 8];
                end
                prioP0 = eg1;
            end else begin
                rspValid = 0;
            end
            if (cntClr) begin
                refCnt = 0; refCnt2 = 0;
            end else if (req0 && req1) begin
                refCnt  = (refCnt  < 65535) ? refCnt + 1  : 65535;
                refCnt2 = (refCnt2 < 3)     ? refCnt2 + 1 : 3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        preloadEn = 1; preloadAddr = a[5:0]; preloadData = d;
        @(posedge clk);
        #1;
        preloadEn = 0;
        refMem[a] = d;
    endtask

    task automatic clearReqs();
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; wstrb0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; wstrb1 = 0;
        cntClr = 0;
    endtask

    task automatic doReset();
        clearReqs();
        rstN = 0;
        repeat (2) edgeAdvance();
        rstN = 1;
    endtask

    task automatic test_reset();
        clearReqs();
        rstN = 0; req0 = 1; req1 = 1;
        repeat (3) edgeAdvance();
        @(negedge clk);
        checks++; if (gnt0 !== 0 || gnt1 !== 0) begin failures++; $display("[TB] FAIL reset_gnt got=%b%b exp=00", gnt0, gnt1); end
        checks++; if (memReq !== 0) begin failures++; $display("[TB] FAIL reset_memreq got=%b exp=0", memReq); end
        checks++; if (rv0 !== 0 || rv1 !== 0) begin failures++; $display("[TB] FAIL reset_rvalid got=%b%b exp=00", rv0, rv1); end
        checks++; if (cnt !== 0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d exp=0", cnt); end
        rstN = 1;
        #1;
        checks++; if (gnt0 !== 1 || gnt1 !== 0) begin failures++; $display("[TB] FAIL reset_first_winner got=%b%b exp=10", gnt0, gnt1); end
        edgeAdvance();
        clearReqs();
        edgeAdvance();
    endtask

    task automatic test_single_read();
        doReset();
        req1 = 1; we1 = 0; addr1 = 14'h10;
        @(negedge clk);
        checks++; if (gnt1 !== 1 || gnt0 !== 0) begin failures++; $display("[TB] FAIL single_gnt got=%b%b exp=01", gnt0, gnt1); end
        edgeAdvance();
        req1 = 0;
        @(negedge clk);
        checks++; if (rv1 !== 1 || rv0 !== 0) begin failures++; $display("[TB] FAIL single_rvalid got=%b%b exp=01", rv0, rv1); end
        checks++; if (rdata1 !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_rdata got=%h exp=deadbeef", rdata1); end
        edgeAdvance();
    endtask

    task automatic test_contention();
        doReset();
        for (int c = 0; c < 6; c++) begin
            req0 = 1; addr0 = 14'(c); req1 = 1; addr1 = 14'(32 + c);
            @(negedge clk);
            predict();
            checks++; if (gnt0 !== (c % 2 == 0) || gnt1 !== (c % 2 == 1)) begin failures++; $display("[TB] FAIL contend_order c=%0d got=%b%b exp_p0=%0d", c, gnt0, gnt1, (c % 2 == 0)); end
            checks++; if (rv0 !== erv0 || rv1 !== erv1) begin failures++; $display("[TB] FAIL contend_route c=%0d got=%b%b exp=%b%b", c, rv0, rv1, erv0, erv1); end
            if (erv0 || erv1) begin
                checks++; if (memRdata !== rspData) begin failures++; $display("[TB] FAIL contend_data c=%0d got=%h exp=%h", c, memRdata, rspData); end
            end
            edgeAdvance();
        end
        clearReqs();
        @(negedge clk);
        checks++; if (rv1 !== 1 || rv0 !== 0) begin failures++; $display("[TB] FAIL contend_last_route got=%b%b exp=01", rv0, rv1); end
        checks++; if (cnt !== 16'd6) begin failures++; $display("[TB] FAIL contend_cnt got=%0d exp=6", cnt); end
        edgeAdvance();
    endtask

    task automatic test_byte_write();
        doReset();
        req1 = 1; we1 = 1; addr1 = 14'h20; wdata1 = 32'h11223344; wstrb1 = 4'b0101;
        @(negedge clk);
        checks++; if (gnt1 !== 1 || memWe !== 1 || memWstrb !== 4'b0101) begin failures++; $display("[TB] FAIL bw_issue got=%b%b%h exp=115", gnt1, memWe, memWstrb); end
        edgeAdvance();
        clearReqs();
        req0 = 1; addr0 = 14'h20;
        @(negedge clk);
        checks++; if (rv1 !== 1 || rdata1 !== 32'hAABBCCDD) begin failures++; $display("[TB] FAIL bw_ack got=%b/%h exp=1/aabbccdd", rv1, rdata1); end
        checks++; if (gnt0 !== 1) begin failures++; $display("[TB] FAIL bw_backtoback got=%b exp=1", gnt0); end
        edgeAdvance();
        clearReqs();
        @(negedge clk);
        checks++; if (rv0 !== 1 || rdata0 !== 32'hAA22CC44) begin failures++; $display("[TB] FAIL bw_readback got=%b/%h exp=1/aa22cc44", rv0, rdata0); end
        edgeAdvance();
    endtask

    task automatic test_saturation();
        doReset();
        req0 = 1; req1 = 1; addr0 = 14'd1; addr1 = 14'd2;
        for (int c = 0; c < 5; c++) begin
            edgeAdvance();
            @(negedge clk);
            checks++; if (cnt2 !== 2'(refCnt2)) begin failures++; $display("[TB] FAIL sat_step c=%0d got=%0d exp=%0d", c, cnt2, refCnt2); end
        end
        checks++; if (cnt2 !== 2'd3) begin failures++; $display("[TB] FAIL sat_hold got=%0d exp=3", cnt2); end
        cntClr = 1;
        edgeAdvance();
        cntClr = 0;
        clearReqs();
        @(negedge clk);
        checks++; if (cnt2 !== 0 || cnt !== 0) begin failures++; $display("[TB] FAIL sat_clear got=%0d/%0d exp=0/0", cnt2, cnt); end
        edgeAdvance();
    endtask

    task automatic test_reset_midop();
        doReset();
        req0 = 1; addr0 = 14'd5;
        @(negedge clk);
        checks++; if (gnt0 !== 1) begin failures++; $display("[TB] FAIL midop_gnt got=%b exp=1", gnt0); end
        rstN = 0;
        edgeAdvance();
        rstN = 1;
        clearReqs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (rv0 !== 0 || rv1 !== 0) begin failures++; $display("[TB] FAIL midop_dropped c=%0d got=%b%b exp=00", c, rv0, rv1); end
            edgeAdvance();
        end
        req0 = 1; addr0 = 14'd5;
        edgeAdvance();
        clearReqs();
        @(negedge clk);
        checks++; if (rv0 !== 1 || rdata0 !== refMem[5]) begin failures++; $display("[TB] FAIL midop_recover got=%b/%h exp=1/%h", rv0, rdata0, refMem[5]); end
        edgeAdvance();
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 300; c++) begin
            if (!req0 && $urandom_range(0, 3) != 0) begin
                req0 = 1; we0 = 1'($urandom_range(0, 1)); addr0 = 14'($urandom_range(0, 63));
                wdata0 = $urandom; wstrb0 = 4'($urandom_range(0, 15));
            end
            if (!req1 && $urandom_range(0, 3) != 0) begin
                req1 = 1; we1 = 1'($urandom_range(0, 1)); addr1 = 14'($urandom_range(0, 63));
                wdata1 = $urandom; wstrb1 = 4'($urandom_range(0, 15));
            end
            cntClr = ($urandom_range(0, 24) == 0);
            @(negedge clk);
            predict();
            checks++; if (gnt0 !== eg0 || gnt1 !== eg1) begin failures++; $display("[TB] FAIL rand_gnt c=%0d got=%b%b exp=%b%b", c, gnt0, gnt1, eg0, eg1); end
            checks++; if (memReq !== (eg0 | eg1)) begin failures++; $display("[TB] FAIL rand_memreq c=%0d got=%b exp=%b", c, memReq, eg0 | eg1); end
            if (eg0 || eg1) begin
                checks++; if (memAddr !== (eg1 ? addr1 : addr0)) begin failures++; $display("[TB] FAIL rand_addr c=%0d got=%h exp=%h", c, memAddr, eg1 ? addr1 : addr0); end
            end
            checks++; if (rv0 !== erv0 || rv1 !== erv1) begin failures++; $display("[TB] FAIL rand_route c=%0d got=%b%b exp=%b%b", c, rv0, rv1, erv0, erv1); end
            if (erv0 || erv1) begin
                checks++; if ((erv0 ? rdata0 : rdata1) !== rspData) begin failures++; $display("[TB] FAIL rand_data c=%0d got=%h exp=%h", c, erv0 ? rdata0 : rdata1, rspData); end
            end
            checks++; if (cnt !== 16'(refCnt)) begin failures++; $display("[TB] FAIL rand_cnt c=%0d got=%0d exp=%0d", c, cnt, refCnt); end
            edgeAdvance();
            if (eg0) req0 = 0;
            if (eg1) req1 = 0;
        end
        clearReqs();
        edgeAdvance();
    endtask

    initial begin
        clearReqs();
        rstN = 0; preloadEn = 0; preloadAddr = 0; preloadData = 0;
        prioP0 = 1; rspValid = 0; rspPort = 0; rspData = 0; refCnt = 0; refCnt2 = 0;
        for (int a = 0; a < 64; a++) preload(a, $urandom);
        preload(16, 32'hDEADBEEF);
        preload(32, 32'hAABBCCDD);
        test_reset();
        test_single_read();
        test_contention();
        test_byte_write();
        test_saturation();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
